// File: rtl/prio_encode_rr_pkg.sv
// Shared definitions for the registered priority encoder: index-width helper and mode encodings.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that never collapses to zero bits, so a two-line encoder still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encode_rr_if.sv
// Request/grant bundle between a requester group and the priority encoder.
interface prio_encode_rr_if #(parameter int N = 8);
    import prio_pkg::*;

    localparam int W = clog2_min1(N);

    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] idx;
    logic [N-1:0] onehot;
    logic         idc;

    modport slave (
        input  en, mode, req, out_ready,
        output out_valid, idx, onehot, idc
    );

    modport master (
        output en, mode, req, out_ready,
        input  out_valid, idx, onehot, idc
    );

endinterface

// File: rtl/prio_encode_rr_scan.sv
// Combinational search for the first set request, walking downward from start-1 with wrap mod N.
module prio_scan #(
    parameter int N = 8
) (
    input  logic [N-1:0]                      req,
    input  logic [prio_pkg::clog2_min1(N)-1:0] start,
    input  logic                              rr,
    output logic                              found,
    output logic [prio_pkg::clog2_min1(N)-1:0] win
);
    import prio_pkg::*;

    localparam int W = clog2_min1(N);

    // Visit candidates from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int sIdx;
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        sIdx  = N - 1;
        if (rr && (start != '0)) begin
            sIdx = int'(start) - 1;
        end
        for (int k = N - 1; k >= 0; k--) begin
            j = (sIdx - k + N) % N;
            if (req[j]) begin
                found = 1'b1;
                win   = W'(j);
            end
        end
    end

endmodule

// File: rtl/prio_encode_rr.sv
// Registered fixed/round-robin priority encoder with a valid/ready output stage.
module prio_encode_rr #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    prio_encode_rr_if.slave     bus
);
    import prio_pkg::*;

    localparam int W = clog2_min1(N);

    logic         r_valid;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_onehot;
    logic         r_idc;
    logic [W-1:0] r_ptr;

    logic         w_load;
    logic         w_found;
    logic [W-1:0] w_win;
    logic [N-1:0] w_onehot;

    prio_scan #(.N(N)) u_scan (
        .req   (bus.req),
        .start (r_ptr),
        .rr    (bus.mode == MODE_RR),
        .found (w_found),
        .win   (w_win)
    );

    // A stalled grant blocks sampling; new requests arriving meanwhile are dropped, not queued.
    assign w_load   = bus.en && (!r_valid || bus.out_ready);
    assign w_onehot = w_found ? (N'(1) << w_win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_idc    <= 1'b0;
            r_ptr    <= '0;
        end else if (w_load) begin
            r_valid  <= w_found;
            r_idc    <= w_found;
            r_idx    <= w_found ? w_win : '0;
            r_onehot <= w_onehot;
            if (w_found && (bus.mode == MODE_RR)) begin
                r_ptr <= w_win;
            end
        end else if (r_valid && bus.out_ready) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.idx       = r_idx;
    assign bus.onehot    = r_onehot;
    assign bus.idc       = r_idc;

endmodule

// File: doc/prio_encode_rr.md
# prio_encode_rr

Parametrised, registered priority encoder and grant selector, the successor to the 8→3 combinational priority encoder. Takes an N-bit request vector, selects one winner by either fixed (highest-index-wins) or round-robin priority, and presents the index, a one-hot grant and an any-request flag through a registered valid/ready output stage. Used where several request lines share one downstream consumer that can stall.

## Interface
- `N`, default 8: number of request lines, ≥2, any integer (non-power-of-two allowed).
- `W`, default `$clog2(N)`: index width. Derived, never overridden.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: sample enable. When low, no new request vector is sampled.
- `mode`, input, 1: 0 = fixed priority, 1 = round-robin. Sampled together with `req`.
- `req`, input, N: request vector.
- `out_ready`, input, 1: downstream accepts the current output.
- `out_valid`, output, 1: `idx`/`onehot` hold a grant.
- `idx`, output, W: winning index.
- `onehot`, output, N: one-hot grant, equal to `1 << idx` when valid, 0 otherwise.
- `idc`, output, 1: the sampled `req` had at least one bit set.

## Operation
- **Load condition:** `load = en && (!out_valid || out_ready)`. Registers update only on `load`.
- **On load, `req` nonzero:** `out_valid`=1, `idc`=1, `idx`/`onehot` = winner.
- **On load, `req` zero:** `out_valid`=0, `idc`=0, `idx`=0, `onehot`=0.
- **Fixed mode:** the highest set index wins.
- **Round-robin mode:**
  - Pointer `ptr` (W bits) holds the last granted index.
  - Search order is `ptr-1`, `ptr-2`, …, 0, N-1, …, `ptr`, with the first set bit winning.
  - The `ptr` reset value is 0, so the first search order equals fixed priority.
  - Wrap is mod N, so index 0 minus 1 maps to N-1 for any N.
- **Pointer update:** `ptr` ← winner only on a load with a nonzero `req` in round-robin mode. Fixed-mode grants and zero requests leave `ptr` unchanged. A mode change does not clear `ptr`.
- **Handshake:** a transfer occurs when `out_valid && out_ready`. The output is held stable while `out_valid && !out_ready`; `req` changes in that window are ignored (not queued).
- **`en` low:** if `out_valid && out_ready`, `out_valid` clears to 0. `idx`/`onehot`/`idc` hold their values except that `onehot` clears with `out_valid`. Otherwise all registers hold.
- **Simultaneous accept and load:** a new grant replaces the accepted one in the same edge, giving back-to-back throughput of one per cycle.

## Timing
- **Latency:** 1 cycle from the sampling edge to `out_valid`/`idx`.
- **Reset values:** `out_valid`=0, `idx`=0, `onehot`=0, `idc`=0, `ptr`=0.
- **Reset mid-operation:** reset applies immediately and asynchronously, and a pending grant is discarded. Deassertion is synchronised externally. The first edge after release may load.
- **Combinational paths:** none from `req`/`mode` to outputs. `out_ready` affects only the next state, with no combinational path to any output.

## Structure
- Shared package `prio_pkg`:
  - Function `clog2_min1(N)`.
  - Constants `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
- One sub-module, `prio_scan`, is natural:
  - Combinational.
  - Inputs: `req[N]`, `start[W]`, `rr`.
  - Outputs: `found`, `win[W]`.
  - Rotates `req` so that the search starts at `start-1` (or N-1 when `rr`=0), finds the highest set bit, and un-rotates mod N.
- The top level holds the output register, `ptr` and the handshake logic.

## Test plan
- **Reset and fixed priority:** reset, then `mode`=0, `en`=1, `out_ready`=1, `req`=8'hA5 → after 1 edge `out_valid`=1, `idx`=7, `onehot`=8'h80, `idc`=1.
- **Round-robin fairness:** `mode`=1, `req`=8'hFF held, `out_ready`=1 → successive `idx` values 7,6,5,4,3,2,1,0,7, one per cycle.
- **Backpressure:**
  - Setup: `mode`=1, grant `idx`=5 (`req`=8'h24), then `out_ready`=0 for 3 cycles while `req` changes to 8'h81 → `idx` stays 5, `onehot`=8'h20, `ptr` unchanged.
  - Release: `out_ready`=1 → next `idx`=0 (search 4..0 finds bit 0).
- **Zero request and `en` low:**
  - `req`=0 with `en`=1 → `out_valid`=0, `idc`=0, `idx`=0.
  - Then `en`=0 with `req`=8'h10 → outputs unchanged.
- **Non-power-of-two N:** with N=5, `mode`=1, `req`=5'b10001 → alternating `idx` 4,0,4,0 (wrap 0→4 verified). `W`=3.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously while `out_valid`=1 and `out_ready`=0 → all outputs 0 before the next edge. After release, `req`=8'hFF in RR mode → `idx`=7 (`ptr` was reset).
